// File: rtl/audio_level_meter_if.sv
// Read-side bus of the audio sample FIFO plus the level outputs to the visualizer.
// master: the level meter; slave: the FIFO / display side.
interface audio_level_meter_if;
    logic        rdempty_sig;
    logic [31:0] q_sig;
    logic        rdreq_sig;
    logic [15:0] left_peak;
    logic [15:0] right_peak;
    logic [15:0] left_avg;
    logic [15:0] right_avg;
    logic        level_valid;

    modport master (
        input  rdempty_sig, q_sig,
        output rdreq_sig, left_peak, right_peak, left_avg, right_avg, level_valid
    );

    modport slave (
        output rdempty_sig, q_sig,
        input  rdreq_sig, left_peak, right_peak, left_avg, right_avg, level_valid
    );
endinterface

// File: rtl/audio_level_meter.sv
// Pops stereo samples from the audio FIFO and publishes per-window peak and mean |x| levels.
// Optional peak hold with per-window decay when LEVEL_PEAK_HOLD_EN is defined.
module audio_level_meter #(
    parameter int unsigned WINDOW_LOG2 = 8,
    parameter logic [15:0] DECAY       = 16'd64
) (
    input  logic                CLOCK_50,
    input  logic                RESET,
    audio_level_meter_if.master bus
);
    localparam int unsigned SAMPLE_W = 16;
    localparam int unsigned ACC_W    = SAMPLE_W + WINDOW_LOG2;

    if (WINDOW_LOG2 < 1 || WINDOW_LOG2 > 12 || DECAY > 16'd32767) begin : g_bad_cfg
        $error("audio_level_meter: WINDOW_LOG2 must be 1..12 and DECAY at most full scale");
    end

    typedef enum logic [2:0] {IDLE, READ, CAPTURE, ACCUM, EMIT} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_rdreq;
    logic                  r_valid;
    logic [SAMPLE_W-1:0]   r_left;
    logic [SAMPLE_W-1:0]   r_right;
    logic [SAMPLE_W-1:0]   r_pk_l;
    logic [SAMPLE_W-1:0]   r_pk_r;
    logic [ACC_W-1:0]      r_sum_l;
    logic [ACC_W-1:0]      r_sum_r;
    logic [WINDOW_LOG2-1:0] r_cnt;
    logic [SAMPLE_W-1:0]   r_lvl_pk_l;
    logic [SAMPLE_W-1:0]   r_lvl_pk_r;
    logic [SAMPLE_W-1:0]   r_lvl_avg_l;
    logic [SAMPLE_W-1:0]   r_lvl_avg_r;

    logic                  w_last;
    logic [SAMPLE_W-1:0]   w_abs_l;
    logic [SAMPLE_W-1:0]   w_abs_r;
    logic [SAMPLE_W-1:0]   w_pk_l;
    logic [SAMPLE_W-1:0]   w_pk_r;
    logic [SAMPLE_W-1:0]   w_pub_pk_l;
    logic [SAMPLE_W-1:0]   w_pub_pk_r;
    logic [ACC_W-1:0]      w_sum_l;
    logic [ACC_W-1:0]      w_sum_r;

    // |s| with -32768 clipped to +32767 so the result fits 15 bits
    function automatic logic [SAMPLE_W-1:0] sat_abs(input logic [SAMPLE_W-1:0] s);
        if (s == 16'h8000)
            return 16'h7FFF;
        else if (s[SAMPLE_W-1])
            return ~s + 16'd1;
        else
            return s;
    endfunction

    function automatic logic [SAMPLE_W-1:0] max16(input logic [SAMPLE_W-1:0] a,
                                                  input logic [SAMPLE_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            r_state <= IDLE;
            r_rdreq <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_rdreq <= (w_state_nxt == READ);
            r_valid <= (w_state_nxt == EMIT);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (!bus.rdempty_sig) w_state_nxt = READ;
            READ:    w_state_nxt = CAPTURE;
            CAPTURE: w_state_nxt = ACCUM;
            ACCUM:   w_state_nxt = w_last ? EMIT : IDLE;
            EMIT:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Accumulator update for the sample held in r_left/r_right, plus the value to publish
    always_comb begin
        w_last  = (r_cnt == '1);
        w_abs_l = sat_abs(r_left);
        w_abs_r = sat_abs(r_right);
        w_pk_l  = max16(r_pk_l, w_abs_l);
        w_pk_r  = max16(r_pk_r, w_abs_r);
        w_sum_l = r_sum_l + ACC_W'(w_abs_l);
        w_sum_r = r_sum_r + ACC_W'(w_abs_r);
`ifdef LEVEL_PEAK_HOLD_EN
        w_pub_pk_l = max16(w_pk_l, (r_lvl_pk_l > DECAY) ? r_lvl_pk_l - DECAY : '0);
        w_pub_pk_r = max16(w_pk_r, (r_lvl_pk_r > DECAY) ? r_lvl_pk_r - DECAY : '0);
`else
        w_pub_pk_l = w_pk_l;
        w_pub_pk_r = w_pk_r;
`endif
    end

    // Levels are loaded on the ACCUM->EMIT edge so they are stable during the valid strobe
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            r_left      <= '0;
            r_right     <= '0;
            r_pk_l      <= '0;
            r_pk_r      <= '0;
            r_sum_l     <= '0;
            r_sum_r     <= '0;
            r_cnt       <= '0;
            r_lvl_pk_l  <= '0;
            r_lvl_pk_r  <= '0;
            r_lvl_avg_l <= '0;
            r_lvl_avg_r <= '0;
        end else begin
            if (r_state == CAPTURE) begin
                r_left  <= bus.q_sig[31:16];
                r_right <= bus.q_sig[15:0];
            end
            if (r_state == ACCUM) begin
                r_cnt <= r_cnt + WINDOW_LOG2'(1);
                if (w_last) begin
                    r_lvl_pk_l  <= w_pub_pk_l;
                    r_lvl_pk_r  <= w_pub_pk_r;
                    r_lvl_avg_l <= SAMPLE_W'(w_sum_l >> WINDOW_LOG2);
                    r_lvl_avg_r <= SAMPLE_W'(w_sum_r >> WINDOW_LOG2);
                    r_pk_l      <= '0;
                    r_pk_r      <= '0;
                    r_sum_l     <= '0;
                    r_sum_r     <= '0;
                end else begin
                    r_pk_l  <= w_pk_l;
                    r_pk_r  <= w_pk_r;
                    r_sum_l <= w_sum_l;
                    r_sum_r <= w_sum_r;
                end
            end
        end
    end

    assign bus.rdreq_sig   = r_rdreq;
    assign bus.level_valid = r_valid;
    assign bus.left_peak   = r_lvl_pk_l;
    assign bus.right_peak  = r_lvl_pk_r;
    assign bus.left_avg    = r_lvl_avg_l;
    assign bus.right_avg   = r_lvl_avg_r;
endmodule

// File: tb/tb_audio_level_meter.sv
// Scoreboard bench for audio_level_meter: two instances (2- and 1-bit windows), each fed by a
// small normal-mode FIFO model; expected levels are queued as samples are pushed.
module tb_audio_level_meter;
    localparam int          WA  = 2;
    localparam int          WB  = 1;
    localparam logic [15:0] DEC = 16'd64;
    localparam int          TMO = 300;

    typedef struct packed {
        logic [15:0] lp;
        logic [15:0] rp;
        logic [15:0] la;
        logic [15:0] ra;
    } lvl_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    audio_level_meter_if if_a ();
    audio_level_meter_if if_b ();

    audio_level_meter #(.WINDOW_LOG2(WA), .DECAY(DEC)) dut_a (
        .CLOCK_50 (clk),
        .RESET    (rst),
        .bus      (if_a)
    );

    audio_level_meter #(.WINDOW_LOG2(WB), .DECAY(DEC)) dut_b (
        .CLOCK_50 (clk),
        .RESET    (rst),
        .bus      (if_b)
    );

    // FIFO models: data appears on q_sig the cycle after rdreq_sig
    logic [31:0] mem_a [64];
    logic [31:0] mem_b [64];
    int unsigned wr_a = 0, rd_a = 0, wr_b = 0, rd_b = 0;
    logic        stall_a = 1'b0, stall_b = 1'b0;
    logic        prev_a = 1'b0, prev_b = 1'b0;
    int unsigned dbl_a = 0, dbl_b = 0, vcnt_a = 0, vcnt_b = 0;

    assign if_a.rdempty_sig = (wr_a == rd_a) || stall_a;
    assign if_b.rdempty_sig = (wr_b == rd_b) || stall_b;

    always @(posedge clk) begin
        if (if_a.rdreq_sig) begin
            if_a.q_sig <= mem_a[rd_a[5:0]];
            rd_a       <= rd_a + 1;
        end
        if (if_a.rdreq_sig && prev_a) dbl_a <= dbl_a + 1;
        prev_a <= if_a.rdreq_sig;
        if (if_a.level_valid) vcnt_a <= vcnt_a + 1;
    end

    always @(posedge clk) begin
        if (if_b.rdreq_sig) begin
            if_b.q_sig <= mem_b[rd_b[5:0]];
            rd_b       <= rd_b + 1;
        end
        if (if_b.rdreq_sig && prev_b) dbl_b <= dbl_b + 1;
        prev_b <= if_b.rdreq_sig;
        if (if_b.level_valid) vcnt_b <= vcnt_b + 1;
    end

    int   n_vec = 0;
    int   n_err = 0;
    lvl_t exp_a [$];
    lvl_t exp_b [$];
    int   m_pk_l [2], m_pk_r [2], m_sum_l [2], m_sum_r [2], m_cnt [2];
    int   m_hold_l [2], m_hold_r [2], n_win [2];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int win(input int s);
        return (s == 0) ? WA : WB;
    endfunction

    function automatic lvl_t levels(input int s);
        lvl_t v;
        if (s == 0) v = '{if_a.left_peak, if_a.right_peak, if_a.left_avg, if_a.right_avg};
        else        v = '{if_b.left_peak, if_b.right_peak, if_b.left_avg, if_b.right_avg};
        return v;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            m_pk_l[s] = 0; m_pk_r[s] = 0; m_sum_l[s] = 0; m_sum_r[s] = 0;
            m_cnt[s] = 0; m_hold_l[s] = 0; m_hold_r[s] = 0;
        end
    endtask

    // Queue one sample into the FIFO of instance s and advance the reference model
    task automatic push(input int s, input int l, input int r);
        logic [15:0] lw, rw;
        int          al, ar, pl, pr;
        lvl_t        e;
        lw = 16'(l);
        rw = 16'(r);
        if (s == 0) begin mem_a[wr_a[5:0]] = {lw, rw}; wr_a++; end
        else        begin mem_b[wr_b[5:0]] = {lw, rw}; wr_b++; end
        al = (l < 0) ? -l : l;
        ar = (r < 0) ? -r : r;
        if (al > 32767) al = 32767;
        if (ar > 32767) ar = 32767;
        if (al > m_pk_l[s]) m_pk_l[s] = al;
        if (ar > m_pk_r[s]) m_pk_r[s] = ar;
        m_sum_l[s] += al;
        m_sum_r[s] += ar;
        m_cnt[s]++;
        if (m_cnt[s] == (1 << win(s))) begin
            pl = m_pk_l[s];
            pr = m_pk_r[s];
`ifdef LEVEL_PEAK_HOLD_EN
            if (m_hold_l[s] - int'(DEC) > pl) pl = m_hold_l[s] - int'(DEC);
            if (m_hold_r[s] - int'(DEC) > pr) pr = m_hold_r[s] - int'(DEC);
            m_hold_l[s] = pl;
            m_hold_r[s] = pr;
`endif
            e.lp = 16'(pl);
            e.rp = 16'(pr);
            e.la = 16'(m_sum_l[s] >> win(s));
            e.ra = 16'(m_sum_r[s] >> win(s));
            if (s == 0) exp_a.push_back(e); else exp_b.push_back(e);
            n_win[s]++;
            m_pk_l[s] = 0; m_pk_r[s] = 0; m_sum_l[s] = 0; m_sum_r[s] = 0; m_cnt[s] = 0;
        end
    endtask

    task automatic push_random_window(input int s);
        logic [15:0] lr, rr;
        for (int i = 0; i < (1 << win(s)); i++) begin
            lr = 16'($urandom);
            rr = 16'($urandom);
            if (i == 0) lr = 16'h8000;
            push(s, int'($signed(lr)), int'($signed(rr)));
        end
    endtask

    // Wait for the next level_valid of instance s and compare against the scoreboard
    task automatic wait_level(input int s, input string tag);
        bit   got;
        logic v;
        lvl_t o, e;
        got = 1'b0;
        for (int i = 0; i < TMO && !got; i++) begin
            @(negedge clk);
            v = (s == 0) ? if_a.level_valid : if_b.level_valid;
            if (v) got = 1'b1;
        end
        if (!got) begin
            check_eq({tag, "_timeout"}, 32'd0, 32'd1);
        end else if ((s == 0 && exp_a.size() == 0) || (s == 1 && exp_b.size() == 0)) begin
            check_eq({tag, "_unexpected_valid"}, 32'd1, 32'd0);
        end else begin
            e = (s == 0) ? exp_a.pop_front() : exp_b.pop_front();
            o = levels(s);
            check_eq({tag, "_left_peak"},  32'(o.lp), 32'(e.lp));
            check_eq({tag, "_right_peak"}, 32'(o.rp), 32'(e.rp));
            check_eq({tag, "_left_avg"},   32'(o.la), 32'(e.la));
            check_eq({tag, "_right_avg"},  32'(o.ra), 32'(e.ra));
        end
    endtask

    task automatic drain(input int s);
        for (int i = 0; i < TMO; i++) begin
            if ((s == 0 && rd_a == wr_a) || (s == 1 && rd_b == wr_b)) break;
            @(negedge clk);
        end
        repeat (4) @(negedge clk);
    endtask

    initial begin
        int          first;
        int unsigned rd0;
        lvl_t        o;
        model_reset();
        n_win[0] = 0;
        n_win[1] = 0;

        // Reset with data waiting: nothing may move until release
        push(0, 100, 0); push(0, -300, 0); push(0, 200, 0); push(0, -50, 0);
        repeat (3) @(negedge clk);
        o = levels(0);
        check_eq("rst_rdreq", 32'(if_a.rdreq_sig), 32'd0);
        check_eq("rst_valid", 32'(if_a.level_valid), 32'd0);
        check_eq("rst_levels", 32'(o.lp | o.rp | o.la | o.ra), 32'd0);
        check_eq("rst_pops", rd_a, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        first = 0;
        for (int k = 1; k <= 8 && first == 0; k++) begin
            @(posedge clk);
            #1;
            if (if_a.rdreq_sig) first = k + 1;
        end
        check_eq("first_rdreq_cycle", 32'(first), 32'd2);
        wait_level(0, "basic");
        repeat (20) @(negedge clk);
        check_eq("basic_nvalid", vcnt_a, 32'(n_win[0]));
        check_eq("basic_hold_peak", 32'(if_a.left_peak), 32'd300);
        check_eq("basic_hold_avg", 32'(if_a.left_avg), 32'd162);

        // Same window with a 50-cycle empty stall between samples 2 and 3
        rd0 = rd_a;
        push(0, 100, 0); push(0, -300, 0);
        drain(0);
        stall_a = 1'b1;
        push(0, 200, 0); push(0, -50, 0);
        check_eq("stall_pre_reads", rd_a - rd0, 32'd2);
        repeat (50) @(negedge clk);
        check_eq("stall_no_rdreq", rd_a - rd0, 32'd2);
        stall_a = 1'b0;
        wait_level(0, "stall");
        check_eq("stall_total_reads", rd_a - rd0, 32'd4);

        // Loud window followed by a silent one
        push(0, 1000, 0); push(0, 0, 0); push(0, 0, 0); push(0, 0, 0);
        wait_level(0, "hold_w1");
        push(0, 0, 0); push(0, 0, 0); push(0, 0, 0); push(0, 0, 0);
        wait_level(0, "hold_w2");
`ifdef LEVEL_PEAK_HOLD_EN
        check_eq("hold_decayed_peak", 32'(if_a.left_peak), 32'd936);
`else
        check_eq("hold_decayed_peak", 32'(if_a.left_peak), 32'd0);
`endif

        push_random_window(0);
        wait_level(0, "rand_a0");
        push_random_window(0);
        wait_level(0, "rand_a1");

        // Full-scale saturation on the two-sample window
        push(1, -32768, 32767); push(1, -32768, 32767);
        wait_level(1, "sat");
        check_eq("sat_left_avg", 32'(if_b.left_avg), 32'd32767);
        push_random_window(1);
        wait_level(1, "rand_b0");
        push(1, 5, -7); push(1, -3, 9);
        wait_level(1, "small_b");

        // Reset after two samples: partial window is dropped
        push(0, 500, -700); push(0, -900, 400);
        drain(0);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        check_eq("midrst_levels", 32'(if_a.left_peak | if_a.left_avg), 32'd0);
        rst = 1'b0;
        rd0 = vcnt_a;
        push(0, 10, 0); push(0, 10, 0); push(0, 10, 0); push(0, 10, 0);
        wait_level(0, "midrst");
        check_eq("midrst_left_peak", 32'(if_a.left_peak), 32'd10);
        check_eq("midrst_left_avg", 32'(if_a.left_avg), 32'd10);
        repeat (20) @(negedge clk);
        check_eq("midrst_nvalid", vcnt_a - rd0, 32'd1);

        check_eq("a_total_valid", vcnt_a, 32'(n_win[0]));
        check_eq("b_total_valid", vcnt_b, 32'(n_win[1]));
        check_eq("a_back2back_rdreq", dbl_a, 32'd0);
        check_eq("b_back2back_rdreq", dbl_b, 32'd0);
        check_eq("a_fifo_drained", rd_a, wr_a);
        check_eq("b_fifo_drained", rd_b, wr_b);
        check_eq("scoreboard_left", 32'(exp_a.size() + exp_b.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/audio_level_meter.md
# audio_level_meter

Read-side consumer of the audio sample FIFO. Pops 32-bit stereo words (left in [31:16], right in [15:0], 16-bit two's complement) whenever the FIFO is non-empty. Computes per-channel absolute peak and mean absolute level over fixed windows of 2^WINDOW_LOG2 samples. Publishes four 16-bit levels with a one-cycle valid strobe for the visualizer display logic.

## Interface
- WINDOW_LOG2, 8: log2 of samples per window; legal range 1..12.
- DECAY, 16'd64: per-window peak-hold decay step; used only with LEVEL_PEAK_HOLD_EN.

- CLOCK_50  input  1  system clock; also the FIFO read clock.
- RESET  input  1  asynchronous, active-high reset.
- rdempty_sig  input  1  FIFO empty flag, synchronous to CLOCK_50.
- q_sig  input  32  FIFO read data. Normal (non-show-ahead) mode: valid the cycle after rdreq_sig.
- rdreq_sig  output  1  FIFO read request; one-cycle pulse per sample.
- left_peak  output  16  window peak of |left|, 0..32767.
- right_peak  output  16  window peak of |right|, 0..32767.
- left_avg  output  16  window mean of |left|, 0..32767.
- right_avg  output  16  window mean of |right|, 0..32767.
- level_valid  output  1  one-cycle strobe; level outputs updated this cycle.

## Operation
- States: IDLE, READ, CAPTURE, ACCUM, EMIT. All outputs are registered.
- IDLE: sample rdempty_sig. If it is 0, go to READ; otherwise stay. rdempty_sig is ignored in every other state.
- READ: rdreq_sig=1 for exactly this cycle. Go to CAPTURE.
- CAPTURE: latch q_sig into left/right sample registers. Go to ACCUM.
- ACCUM: for each channel:
  - abs = (s<0) ? -s : s, with -32768 saturated to 32767.
  - peak_acc = max(peak_acc, abs).
  - sum_acc += abs.
  - Increment sample_cnt (WINDOW_LOG2 bits, wrapping).
  - If sample_cnt was 2^WINDOW_LOG2-1, go to EMIT; else go to IDLE.
- EMIT:
  - peak outputs <= peak_acc (see Configuration).
  - avg outputs <= sum_acc >> WINDOW_LOG2 (truncating).
  - level_valid=1 for this cycle.
  - Clear peak_acc and sum_acc.
  - Go to IDLE.
- Widths: abs is 16-bit unsigned. sum_acc is 16+WINDOW_LOG2 bits and cannot overflow. avg is taken from the low 16 bits of the shifted sum and is at most 32767.
- Level outputs hold their values between EMITs.
- Stalls (rdempty_sig high) may occur anywhere within a window and do not affect results.
- Reset mid-window discards the partial window. No level_valid is emitted for the discarded window.

## Timing
- Reset values: rdreq_sig=0, level_valid=0, all level outputs=0, state=IDLE, sample_cnt=0, accumulators=0.
- Minimum 4 cycles per sample (IDLE→READ→CAPTURE→ACCUM). The window-closing sample takes 5 cycles (adds EMIT).
- The first rdreq_sig is asserted 1 cycle after the IDLE cycle that sees rdempty_sig=0.
- level_valid asserts 2 cycles after the CAPTURE of the last window sample.
- At most one outstanding read; rdreq_sig is never asserted on consecutive cycles.
- At 48 kHz input this gives more than 250x read-side headroom, so the FIFO never fills from this side.

## Configuration
- Macro: LEVEL_PEAK_HOLD_EN.
- Defined: in EMIT, each peak output <= max(peak_acc, held - DECAY), where held is the previous peak output.
  - held - DECAY floors at 0 (unsigned saturating subtract).
  - Averages are unaffected.
- Undefined: peak outputs <= peak_acc; no hold register and no DECAY logic is synthesized.

## Test plan
- Reset:
  - Stimulus: assert RESET with rdempty_sig=0.
  - Required: rdreq_sig=0, level_valid=0, all levels 0. First rdreq_sig occurs 2 cycles after RESET deasserts.
- Basic window:
  - Stimulus: WINDOW_LOG2=2; left = +100, -300, +200, -50; right = 0.
  - Required: exactly one level_valid; left_peak=300, left_avg=162, right_peak=0, right_avg=0.
- Saturation:
  - Stimulus: WINDOW_LOG2=1; two samples with left=-32768, right=+32767.
  - Required: left_peak=32767, left_avg=32767, right_peak=32767, right_avg=32767.
- Stalls:
  - Stimulus: WINDOW_LOG2=2, same samples as the basic window test; rdempty_sig held high for 50 cycles between samples 2 and 3.
  - Required: identical results to the basic window test; rdreq_sig stays 0 during the stall; exactly 4 rdreq_sig pulses total.
- Peak hold:
  - Stimulus: DECAY=64; window 1 peak 1000, window 2 all zeros.
  - Required: window 2 left_peak = 936 with LEVEL_PEAK_HOLD_EN defined, 0 without it.
- Reset mid-window:
  - Stimulus: WINDOW_LOG2=2; RESET asserted after 2 samples; then 4 samples of left=+10.
  - Required: a single level_valid with left_peak=10 and left_avg=10.
